decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 211 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: turns an RV32 instruction word into an op code, register
// indices and a sign-extended immediate. A register scoreboard tracks pending
// writes and stalls consumers of those registers until writeback.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int M_EXT = 1,
   parameter int OP_W  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OP_W-1:0] out_op,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd
);

   localparam logic [OP_W-1:0] OP_ADD     = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB     = OP_W'(1);
   localparam logic [OP_W-1:0] OP_MUL     = OP_W'(2);
   localparam logic [OP_W-1:0] OP_DIV     = OP_W'(3);
   localparam logic [OP_W-1:0] OP_LOAD    = OP_W'(4);
   localparam logic [OP_W-1:0] OP_STORE   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_ADDI    = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BRANCH  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_LUI     = OP_W'(8);
   localparam logic [OP_W-1:0] OP_AUIPC   = OP_W'(9);
   localparam logic [OP_W-1:0] OP_JAL     = OP_W'(10);
   localparam logic [OP_W-1:0] OP_JALR    = OP_W'(11);
   localparam logic [OP_W-1:0] OP_ILLEGAL = OP_W'(15);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [OP_W-1:0] op;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_ext;
   logic            illegal;
   logic            use_rs1;
   logic            use_rs2;
   logic            writes_rd;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            hazard;
   logic            accept;
   logic [31:0]     scoreboard;
   logic [31:0]     scoreboard_next;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign rd     = in_instr[11:7];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];

   // Classify the instruction, pick its immediate format and register usage
   always_comb begin
      op        = OP_ILLEGAL;
      imm32     = '0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      writes_rd = 1'b0;
      case (opcode)
         7'b0110011: begin
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            writes_rd = 1'b1;
            case ({funct7, funct3})
               10'b0000000_000: op = OP_ADD;
               10'b0100000_000: op = OP_SUB;
               10'b0000001_000: op = (M_EXT != 0) ? OP_MUL : OP_ILLEGAL;
               10'b0000001_100: op = (M_EXT != 0) ? OP_DIV : OP_ILLEGAL;
               default:         op = OP_ILLEGAL;
            endcase
         end
         7'b0000011: begin
            op        = (funct3 == 3'b010) ? OP_LOAD : OP_ILLEGAL;
            imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
            use_rs1   = 1'b1;
            writes_rd = 1'b1;
         end
         7'b0100011: begin
            op      = (funct3 == 3'b010) ? OP_STORE : OP_ILLEGAL;
            imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         7'b0010011: begin
            op        = (funct3 == 3'b000) ? OP_ADDI : OP_ILLEGAL;
            imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
            use_rs1   = 1'b1;
            writes_rd = 1'b1;
         end
         7'b1100011: begin
            op      = OP_BRANCH;
            imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         7'b0110111: begin
            op        = OP_LUI;
            imm32     = {in_instr[31:12], 12'b0};
            writes_rd = 1'b1;
         end
         7'b0010111: begin
            op        = OP_AUIPC;
            imm32     = {in_instr[31:12], 12'b0};
            writes_rd = 1'b1;
         end
         7'b1101111: begin
            op        = OP_JAL;
            imm32     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            writes_rd = 1'b1;
         end
         7'b1100111: begin
            op        = (funct3 == 3'b000) ? OP_JALR : OP_ILLEGAL;
            imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
            use_rs1   = 1'b1;
            writes_rd = 1'b1;
         end
         default: op = OP_ILLEGAL;
      endcase
      // An unsupported encoding carries no immediate and touches no registers,
      // so it can never stall or mark the scoreboard.
      if (op == OP_ILLEGAL) begin
         imm32     = '0;
         use_rs1   = 1'b0;
         use_rs2   = 1'b0;
         writes_rd = 1'b0;
      end
      if (rd == 5'd0) begin
         writes_rd = 1'b0;
      end
   end

   assign illegal  = (op == OP_ILLEGAL);
   assign imm_ext  = XLEN'($signed(imm32));

   assign rs1_busy = use_rs1 && scoreboard[rs1] && !(wb_valid && (wb_rd == rs1));
   assign rs2_busy = use_rs2 && scoreboard[rs2] && !(wb_valid && (wb_rd == rs2));
   assign hazard   = rs1_busy || rs2_busy;
   assign in_ready = !flush && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Next scoreboard: writeback clears first so a same-cycle set on that register wins
   always_comb begin
      scoreboard_next = scoreboard;
      if (wb_valid) begin
         scoreboard_next[wb_rd] = 1'b0;
      end
      if (accept && writes_rd) begin
         scoreboard_next[rd] = 1'b1;
      end
      scoreboard_next[0] = 1'b0;
   end

   // Scoreboard register; flush wipes every pending write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scoreboard <= '0;
      end else if (flush) begin
         scoreboard <= '0;
      end else begin
         scoreboard <= scoreboard_next;
      end
   end

   // Output bundle register with valid/ready hold and flush squash
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_op      <= '0;
         out_rd      <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_imm     <= '0;
         out_pc      <= '0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_op      <= op;
         out_rd      <= rd;
         out_rs1     <= rs1;
         out_rs2     <= rs2;
         out_imm     <= imm_ext;
         out_pc      <= in_pc;
         out_illegal <= illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed instructions with hand-computed op codes
// and immediates; a queue-based scoreboard checks every bundle the DUT hands over.
module tb_decode_stage;

   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        illegal;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [3:0]  out_op;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [31:0] out_imm;
   logic [31:0] out_pc;
   logic        out_illegal;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;

   logic        n_in_valid = 1'b0;
   logic        n_in_ready;
   logic [31:0] n_in_instr = '0;
   logic        n_out_valid;
   logic [3:0]  n_out_op;
   logic [4:0]  n_out_rd;
   logic [4:0]  n_out_rs1;
   logic [4:0]  n_out_rs2;
   logic [31:0] n_out_imm;
   logic [31:0] n_out_pc;
   logic        n_out_illegal;

   int          errors = 0;
   int          checks = 0;
   bundle_t     exp_q[$];
   bundle_t     got;
   logic [31:0] next_pc = 32'h100;

   decode_stage #(.XLEN(32), .M_EXT(1), .OP_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal),
      .wb_valid(wb_valid), .wb_rd(wb_rd)
   );

   decode_stage #(.XLEN(32), .M_EXT(0), .OP_W(4)) u_noext (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(n_in_valid), .in_ready(n_in_ready), .in_instr(n_in_instr), .in_pc(32'h40),
      .out_valid(n_out_valid), .out_ready(1'b1), .out_op(n_out_op),
      .out_rd(n_out_rd), .out_rs1(n_out_rs1), .out_rs2(n_out_rs2),
      .out_imm(n_out_imm), .out_pc(n_out_pc), .out_illegal(n_out_illegal),
      .wb_valid(1'b0), .wb_rd(5'd0)
   );

   always #5 clk = ~clk;

   // Global watchdog so a stuck handshake can never hang the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic bundle_t make_exp(input logic [31:0] instr, input logic [31:0] pc,
                                        input logic [3:0] op, input logic [31:0] imm,
                                        input logic ill);
      bundle_t b;
      b.op      = op;
      b.rd      = instr[11:7];
      b.rs1     = instr[19:15];
      b.rs2     = instr[24:20];
      b.imm     = imm;
      b.pc      = pc;
      b.illegal = ill;
      return b;
   endfunction

   // Offer one instruction and wait (bounded) for it to be accepted
   task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] op,
                                input logic [31:0] imm, input logic ill);
      bit done = 0;
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = next_pc;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(make_exp(instr, next_pc, op, imm, ill));
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      next_pc  = next_pc + 32'd4;
   endtask

   // Monitor: every completed output handshake must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_output", 64'd1, 64'd0);
         end else begin
            got = exp_q.pop_front();
            checkOutput("out_op", 64'(out_op), 64'(got.op));
            checkOutput("out_rd", 64'(out_rd), 64'(got.rd));
            checkOutput("out_rs1", 64'(out_rs1), 64'(got.rs1));
            checkOutput("out_rs2", 64'(out_rs2), 64'(got.rs2));
            checkOutput("out_imm", 64'(out_imm), 64'(got.imm));
            checkOutput("out_pc", 64'(out_pc), 64'(got.pc));
            checkOutput("out_illegal", 64'(out_illegal), 64'(got.illegal));
         end
      end
   end

   // Directed scenario sequence
   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_op", 64'(out_op), 64'd0);
      checkOutput("rst_out_rd", 64'(out_rd), 64'd0);
      checkOutput("rst_out_imm", 64'(out_imm), 64'd0);
      checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
      checkOutput("rst_out_illegal", 64'(out_illegal), 64'd0);
      checkOutput("rst_scoreboard", 64'(dut.scoreboard), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ADDI x5,x0,-1 marks x5 pending
      applyStimulus(32'hFFF00293, 4'd6, 32'hFFFFFFFF, 1'b0);
      checkOutput("sb5_set", 64'(dut.scoreboard[5]), 64'd1);

      // ADD x6,x5,x5 stalls until writeback of x5, accepted in that same cycle
      in_valid = 1'b1;
      in_instr = 32'h00528333;
      in_pc    = next_pc;
      repeat (2) begin
         @(negedge clk);
         checkOutput("raw_stall_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      wb_valid = 1'b1;
      wb_rd    = 5'd5;
      @(negedge clk);
      checkOutput("wb_bypass_in_ready", 64'(in_ready), 64'd1);
      if (in_ready) exp_q.push_back(make_exp(32'h00528333, next_pc, 4'd0, 32'd0, 1'b0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wb_valid = 1'b0;
      next_pc  = next_pc + 32'd4;
      checkOutput("sb_after_add", 64'(dut.scoreboard), 64'h40);

      // LUI x7 then AUIPC x7 accepted alongside writeback of x7: set wins
      applyStimulus(32'h123453B7, 4'd8, 32'h12345000, 1'b0);
      in_valid = 1'b1;
      in_instr = 32'h00001397;
      in_pc    = next_pc;
      wb_valid = 1'b1;
      wb_rd    = 5'd7;
      @(negedge clk);
      checkOutput("auipc_in_ready", 64'(in_ready), 64'd1);
      if (in_ready) exp_q.push_back(make_exp(32'h00001397, next_pc, 4'd9, 32'h00001000, 1'b0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      next_pc  = next_pc + 32'd4;
      checkOutput("sb7_set_wins", 64'(dut.scoreboard[7]), 64'd1);
      wb_rd = 5'd7;
      @(posedge clk);
      #1;
      checkOutput("sb7_cleared", 64'(dut.scoreboard[7]), 64'd0);
      wb_rd = 5'd6;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      checkOutput("sb_empty", 64'(dut.scoreboard), 64'd0);

      // Remaining formats, M extension, an illegal word and a write to x0
      applyStimulus(32'h001000EF, 4'd10, 32'h00000800, 1'b0);
      applyStimulus(32'hFF812403, 4'd4, 32'hFFFFFFF8, 1'b0);
      applyStimulus(32'h40B504B3, 4'd1, 32'd0, 1'b0);
      applyStimulus(32'h023100B3, 4'd2, 32'd0, 1'b0);
      applyStimulus(32'h02E6C633, 4'd3, 32'd0, 1'b0);
      applyStimulus(32'hFFFFFFFF, 4'd15, 32'd0, 1'b1);
      checkOutput("illegal_no_sb", 64'(dut.scoreboard[31]), 64'd0);
      applyStimulus(32'h00000013, 4'd6, 32'd0, 1'b0);
      checkOutput("sb_x0_zero", 64'(dut.scoreboard[0]), 64'd0);
      @(posedge clk);
      #1;

      // Back-pressure: STORE held for 3 cycles while BRANCH waits
      out_ready = 1'b0;
      applyStimulus(32'h0041A423, 4'd5, 32'd8, 1'b0);
      in_valid = 1'b1;
      in_instr = 32'hFE418EE3;
      in_pc    = next_pc;
      repeat (3) begin
         @(negedge clk);
         checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
         checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
         checkOutput("stall_out_op", 64'(out_op), 64'd5);
         checkOutput("stall_out_imm", 64'(out_imm), 64'd8);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("release_in_ready", 64'(in_ready), 64'd1);
      if (in_ready) exp_q.push_back(make_exp(32'hFE418EE3, next_pc, 4'd7, 32'hFFFFFFFC, 1'b0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      next_pc  = next_pc + 32'd4;

      // Flush with a valid bundle and pending registers
      checkOutput("sb_before_flush", 64'(dut.scoreboard), 64'h1302);
      flush = 1'b1;
      @(negedge clk);
      checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_scoreboard", 64'(dut.scoreboard), 64'd0);

      // Reset in the middle of a stall discards the held bundle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00293;
      in_pc     = 32'h200;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("prerst_out_valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_out_op", 64'(out_op), 64'd0);
      checkOutput("midrst_out_rd", 64'(out_rd), 64'd0);
      checkOutput("midrst_out_imm", 64'(out_imm), 64'd0);
      checkOutput("midrst_out_pc", 64'(out_pc), 64'd0);
      checkOutput("midrst_scoreboard", 64'(dut.scoreboard), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;

      // Without the M extension MUL decodes as illegal
      n_in_valid = 1'b1;
      n_in_instr = 32'h023100B3;
      @(negedge clk);
      checkOutput("noext_in_ready", 64'(n_in_ready), 64'd1);
      @(posedge clk);
      #1;
      n_in_valid = 1'b0;
      checkOutput("noext_out_valid", 64'(n_out_valid), 64'd1);
      checkOutput("noext_out_op", 64'(n_out_op), 64'd15);
      checkOutput("noext_out_illegal", 64'(n_out_illegal), 64'd1);
      checkOutput("noext_out_rd", 64'(n_out_rd), 64'd1);
      checkOutput("noext_out_imm", 64'(n_out_imm), 64'd0);
      checkOutput("noext_scoreboard", 64'(u_noext.scoreboard), 64'd0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("pending_expectations", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
